uc_sched_ctrl: RTL and testbench
================================

# uc_sched_ctrl

Sequencing controller and arbiter for unit-clause (UC) propagation in the BCP engine array. It first streams initial unit clauses from memory, then round-robin arbitrates the head literals of `NUM_ENGINE` engine queues. It broadcasts each new literal to all engines, stalls while any engine queue is full, and flags conflicts against a per-variable assignment table. It sits between the clause memory loader and the engine array.

## Interface
- `NUM_ENGINE`, 4, number of BCP engines
- `LIT_IDX_MAX`, 64, largest variable index; literal width `LW = $clog2(LIT_IDX_MAX)+1` bits, signed; sign = polarity; literal 0 = invalid
- `clk  in  1  clock`, rising edge
- `rst  in  1  reset`, asynchronous, active-high
- `mem2ucs_valid  in  1  memory literal valid`
- `mem2ucs_done  in  1  memory UC stream finished` (level, sampled in MEM)
- `mem2ucs  in  LW  memory literal`
- `mem2ucs_ready  out  1  memory literal accepted this cycle when valid`
- `eng2ucs_min  in  NUM_ENGINE×LW  head literal per engine`
- `eng2ucs_valid  in  NUM_ENGINE  head valid per engine`
- `eng2ucs_full  in  NUM_ENGINE  engine input queue full`
- `ucs2eng_grant  out  NUM_ENGINE  one-hot pop to the engine whose head was taken`
- `ucs2eng  out  LW  broadcast literal`
- `ucs2eng_valid  out  1  broadcast valid`
- `input_mode  out  1  1 = memory phase, 0 = engine phase`
- `conflict  out  1  sticky conflict flag`

## Operation
- Table: `LIT_IDX_MAX+1` entries of {assigned, polarity}, indexed by |literal|; cleared on reset.
- `stall` = OR of `eng2ucs_full`. While stalled: no acceptance, `mem2ucs_ready`=0, grant=0; the broadcast register keeps its value, and `ucs2eng_valid` drops to 0 after one cycle.
- FSM states:
  - MEM (reset state): `input_mode`=1, `mem2ucs_ready` = !stall. Accept on valid&&ready. When `mem2ucs_done`=1 and no literal is accepted that cycle, go to ENG. If done and valid occur in the same cycle, accept the literal first and transition on the next cycle.
  - ENG: `input_mode`=0, `mem2ucs_ready`=0. If !stall, grant the first engine with valid=1, searching from `rr_ptr` upward with wrap. On a grant, set `rr_ptr` = granted+1 mod `NUM_ENGINE`. No valid engine: no grant. ENG persists until reset.
  - CONFLICT: terminal until reset. No grants, `mem2ucs_ready`=0, `ucs2eng_valid`=0, `conflict`=1.
- Accepted literal L (from memory or engine) with v=|L|:
  - L=0 or v>LIT_IDX_MAX: consumed (ready or grant asserted), no broadcast, no table change.
  - Entry v unassigned: set assigned, polarity=sign(L); broadcast L.
  - Entry v assigned, same polarity: duplicate; consumed, no broadcast.
  - Entry v assigned, opposite polarity: consumed, no broadcast; go to CONFLICT.
- One acceptance at most per cycle. The table updates at the accept edge, so a back-to-back identical literal is already detected as a duplicate.

## Timing
- Reset values: `ucs2eng`=0, `ucs2eng_valid`=0, `ucs2eng_grant`=0, `mem2ucs_ready`=0 in the reset cycle then !stall, `input_mode`=1, `conflict`=0, `rr_ptr`=0, state MEM.
- `mem2ucs_ready` and `ucs2eng_grant` are combinational in the accept cycle N. The engine pops its head at the edge ending N.
- Broadcast is registered: `ucs2eng`/`ucs2eng_valid` appear in cycle N+1 for one cycle. Throughput is 1 literal/cycle.
- `conflict` is registered: it rises in N+1 and holds until `rst`.
- MEM→ENG takes 1 cycle after done is sampled. The first grant is possible in the first ENG cycle.
- `eng2ucs_full` asserting in cycle N blocks acceptance in N; there is no skid.
- Reset mid-operation: asynchronous clear of every state element above. An in-flight broadcast is lost.

## Test plan
- NUM_ENGINE=4, LIT_IDX_MAX=64 for all scenarios.
- Memory streams 10,20,30,40,50 back-to-back, then done=1 → `ucs2eng` = 10..50 on consecutive cycles, each one cycle after its accept; `input_mode` falls the cycle after done is sampled.
- ENG phase, engines 1 and 3 valid with 2 and 4 held for 4 cycles → grants 0010, 1000, 0010, 1000; broadcast 2, 4, then no valid (duplicates). All four engines valid with distinct fresh literals → grant order 0,1,2,3,0.
- Memory 10; then engine 0 offers 10 → grant 0001, `ucs2eng_valid` stays 0, `conflict` stays 0.
- Memory 10; then engine 2 offers −10 → grant 0100, `conflict`=1 the next cycle and held for 20 cycles, no further grants or broadcasts although engines stay valid.
- `eng2ucs_full[2]`=1 for 5 cycles with memory valid (and, separately, engines valid) → ready=0 and grant=0 throughout; acceptance resumes the cycle full drops with no literal lost or duplicated.
- `rst` pulsed mid-ENG after 10 was broadcast → all outputs at reset values, `input_mode`=1; a following memory −10 broadcasts −10 with no conflict.

Source files
------------

// File: rtl/uc_sched_ctrl_if.sv
// Handshake bundle between the clause memory loader, the UC scheduler and the BCP engine array.
// master = scheduler side, slave = loader/engine side.
interface uc_sched_ctrl_if #(
   parameter int NUM_ENGINE  = 4,
   parameter int LIT_IDX_MAX = 64
);
   localparam int LW = $clog2(LIT_IDX_MAX) + 1;

   logic                           mem2ucs_valid;
   logic                           mem2ucs_done;
   logic [LW-1:0]                  mem2ucs;
   logic                           mem2ucs_ready;
   logic [NUM_ENGINE-1:0][LW-1:0]  eng2ucs_min;
   logic [NUM_ENGINE-1:0]          eng2ucs_valid;
   logic [NUM_ENGINE-1:0]          eng2ucs_full;
   logic [NUM_ENGINE-1:0]          ucs2eng_grant;
   logic [LW-1:0]                  ucs2eng;
   logic                           ucs2eng_valid;
   logic                           input_mode;
   logic                           conflict;

   modport master (
      input  mem2ucs_valid, mem2ucs_done, mem2ucs, eng2ucs_min, eng2ucs_valid, eng2ucs_full,
      output mem2ucs_ready, ucs2eng_grant, ucs2eng, ucs2eng_valid, input_mode, conflict
   );

   modport slave (
      output mem2ucs_valid, mem2ucs_done, mem2ucs, eng2ucs_min, eng2ucs_valid, eng2ucs_full,
      input  mem2ucs_ready, ucs2eng_grant, ucs2eng, ucs2eng_valid, input_mode, conflict
   );
endinterface

// File: rtl/uc_sched_ctrl.sv
// UC propagation sequencer: streams memory unit clauses, then round-robin arbitrates engine heads.
// Ready/grant combinational, broadcast and conflict one cycle later; any engine full stalls acceptance.
module uc_sched_ctrl #(
   parameter int NUM_ENGINE  = 4,
   parameter int LIT_IDX_MAX = 64
) (
   input  logic                clk,
   input  logic                rst,
   uc_sched_ctrl_if.master     bus
);
   localparam int LW = $clog2(LIT_IDX_MAX) + 1;
   localparam int PW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
   localparam int IW = $clog2(LIT_IDX_MAX + 1);

   localparam logic [1:0] ST_MEM      = 2'd0;
   localparam logic [1:0] ST_ENG      = 2'd1;
   localparam logic [1:0] ST_CONFLICT = 2'd2;

   logic [1:0]             state;
   logic [PW-1:0]          rr_ptr;
   logic [LIT_IDX_MAX:0]   tbl_asg;
   logic [LIT_IDX_MAX:0]   tbl_pol;
   logic [LW-1:0]          bcast_lit;
   logic                   bcast_vld;

   logic                   stall;
   logic                   mem_acc;
   logic                   eng_open;
   logic                   gnt_any;
   logic [PW-1:0]          gnt_idx;
   logic [PW-1:0]          cand;
   logic [PW-1:0]          rr_next;
   logic                   acc;
   logic [LW-1:0]          acc_lit;
   logic [LW-1:0]          mag;
   logic                   in_range;
   logic [IW-1:0]          tbl_idx;
   logic                   fresh;
   logic                   clash;

   assign stall    = |bus.eng2ucs_full;
   assign bus.mem2ucs_ready = (state == ST_MEM) && !stall && !rst;
   assign mem_acc  = bus.mem2ucs_ready && bus.mem2ucs_valid;
   assign eng_open = (state == ST_ENG) && !stall;

   // First valid engine at or above rr_ptr, wrapping.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = 0; i < NUM_ENGINE; i++) begin
         cand = PW'((int'(rr_ptr) + i) % NUM_ENGINE);
         if (eng_open && !gnt_any && bus.eng2ucs_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign bus.ucs2eng_grant = gnt_any ? (NUM_ENGINE'(1) << gnt_idx) : '0;
   assign rr_next = (gnt_idx == PW'(NUM_ENGINE - 1)) ? '0 : gnt_idx + PW'(1);

   assign acc      = mem_acc || gnt_any;
   assign acc_lit  = mem_acc ? bus.mem2ucs : bus.eng2ucs_min[gnt_idx];
   assign mag      = acc_lit[LW-1] ? (~acc_lit + LW'(1)) : acc_lit;
   assign in_range = (acc_lit != '0) && (int'(mag) <= LIT_IDX_MAX);
   assign tbl_idx  = in_range ? IW'(mag) : '0;
   assign fresh    = acc && in_range && !tbl_asg[tbl_idx];
   assign clash    = acc && in_range && tbl_asg[tbl_idx] && (tbl_pol[tbl_idx] != acc_lit[LW-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_MEM;
         rr_ptr    <= '0;
         tbl_asg   <= '0;
         tbl_pol   <= '0;
         bcast_lit <= '0;
         bcast_vld <= 1'b0;
      end else begin
         bcast_vld <= fresh;
         if (fresh) begin
            bcast_lit         <= acc_lit;
            tbl_asg[tbl_idx]  <= 1'b1;
            tbl_pol[tbl_idx]  <= acc_lit[LW-1];
         end
         if (gnt_any) rr_ptr <= rr_next;
         // A literal accepted alongside done is drained before leaving the memory phase.
         if (clash)
            state <= ST_CONFLICT;
         else if (state == ST_MEM && bus.mem2ucs_done && !mem_acc)
            state <= ST_ENG;
      end
   end

   assign bus.ucs2eng       = bcast_lit;
   assign bus.ucs2eng_valid = bcast_vld;
   assign bus.input_mode    = (state == ST_MEM);
   assign bus.conflict      = (state == ST_CONFLICT);
endmodule

// File: tb/tb_uc_sched_ctrl.sv
// Bench for uc_sched_ctrl: directed scenarios plus randomized episodes against a literal-level reference model.
module tb_uc_sched_ctrl;
   localparam int NE  = 4;
   localparam int LIM = 64;
   localparam int LW  = $clog2(LIM) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   uc_sched_ctrl_if #(.NUM_ENGINE(NE), .LIT_IDX_MAX(LIM)) bus ();
   uc_sched_ctrl #(.NUM_ENGINE(NE), .LIT_IDX_MAX(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Reference model: assignment map var -> +1/-1, phase flags, round-robin pointer.
   int        m_tbl[int];
   bit        m_loading, m_conf;
   int        m_ptr;
   logic      exp_rdy;
   logic [NE-1:0] exp_gnt;
   int        exp_ucs;
   logic      exp_uv;
   bit        acc_now, mem_acc_now;
   int        acc_lit, gnt_e;

   function automatic logic [LW-1:0] to_lit(input int x);
      return LW'(x);
   endfunction

   function automatic int from_lit(input logic [LW-1:0] l);
      return int'($signed(l));
   endfunction

   function automatic logic exp_mode();
      return m_loading && !m_conf;
   endfunction

   task automatic model_reset();
      m_tbl.delete();
      m_loading = 1'b1;
      m_conf    = 1'b0;
      m_ptr     = 0;
      exp_ucs   = 0;
      exp_uv    = 1'b0;
   endtask

   task automatic model_eval();
      bit stalled;
      stalled     = (bus.eng2ucs_full != '0);
      exp_rdy     = !rst && m_loading && !m_conf && !stalled;
      exp_gnt     = '0;
      acc_now     = 1'b0;
      mem_acc_now = 1'b0;
      gnt_e       = -1;
      if (exp_rdy && bus.mem2ucs_valid) begin
         acc_now = 1'b1; mem_acc_now = 1'b1; acc_lit = from_lit(bus.mem2ucs);
      end else if (!m_loading && !m_conf && !stalled) begin
         for (int k = 0; k < NE; k++) begin
            int e;
            e = (m_ptr + k) % NE;
            if (gnt_e < 0 && bus.eng2ucs_valid[e]) begin
               gnt_e = e; exp_gnt[e] = 1'b1; acc_now = 1'b1; acc_lit = from_lit(bus.eng2ucs_min[e]);
            end
         end
      end
   endtask

   task automatic model_commit();
      int v, s;
      exp_uv = 1'b0;
      if (acc_now && acc_lit != 0) begin
         v = (acc_lit < 0) ? -acc_lit : acc_lit;
         s = (acc_lit < 0) ? -1 : 1;
         if (v <= LIM) begin
            if (!m_tbl.exists(v)) begin
               m_tbl[v] = s; exp_uv = 1'b1; exp_ucs = acc_lit;
            end else if (m_tbl[v] != s) begin
               m_conf = 1'b1;
            end
         end
      end
      if (gnt_e >= 0) m_ptr = (gnt_e + 1) % NE;
      if (m_loading && bus.mem2ucs_done && !mem_acc_now) m_loading = 1'b0;
   endtask

   task automatic set_idle();
      bus.mem2ucs_valid = 1'b0;
      bus.mem2ucs_done  = 1'b0;
      bus.mem2ucs       = '0;
      bus.eng2ucs_min   = '0;
      bus.eng2ucs_valid = '0;
      bus.eng2ucs_full  = '0;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic advance();
      model_commit();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_idle();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic mem_cycle(input int lit, input bit done);
      bus.mem2ucs_valid = (lit != 0);
      bus.mem2ucs       = to_lit(lit);
      bus.mem2ucs_done  = done;
      settle();
      advance();
      set_idle();
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      settle();
      n_tot++; if (bus.mem2ucs_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.mem2ucs_ready); else n_pass++;
      n_tot++; if (bus.ucs2eng !== '0) $display("FAIL rst_ucs2eng: got %0d want 0", bus.ucs2eng); else n_pass++;
      n_tot++; if (bus.ucs2eng_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.ucs2eng_valid); else n_pass++;
      n_tot++; if (bus.ucs2eng_grant !== '0) $display("FAIL rst_grant: got %b want 0", bus.ucs2eng_grant); else n_pass++;
      n_tot++; if (bus.input_mode !== 1'b1) $display("FAIL rst_mode: got %b want 1", bus.input_mode); else n_pass++;
      n_tot++; if (bus.conflict !== 1'b0) $display("FAIL rst_conflict: got %b want 0", bus.conflict); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      settle();
      n_tot++; if (bus.mem2ucs_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", bus.mem2ucs_ready); else n_pass++;
      advance();
   endtask

   task automatic test_mem_stream();
      int lits[5] = '{10, 20, 30, 40, 50};
      do_reset();
      for (int i = 0; i <= 5; i++) begin
         bus.mem2ucs_valid = (i < 5);
         bus.mem2ucs       = to_lit((i < 5) ? lits[i] : 0);
         bus.mem2ucs_done  = (i == 5);
         settle();
         n_tot++; if (bus.mem2ucs_ready !== 1'b1) $display("FAIL mem_ready[%0d]: got %b want 1", i, bus.mem2ucs_ready); else n_pass++;
         advance();
         if (i < 5) begin
            n_tot++; if (bus.ucs2eng_valid !== 1'b1 || from_lit(bus.ucs2eng) !== lits[i])
               $display("FAIL mem_bcast[%0d]: got v=%b lit=%0d want v=1 lit=%0d", i, bus.ucs2eng_valid, from_lit(bus.ucs2eng), lits[i]);
            else n_pass++;
            n_tot++; if (bus.input_mode !== 1'b1) $display("FAIL mem_mode[%0d]: got %b want 1", i, bus.input_mode); else n_pass++;
         end else begin
            n_tot++; if (bus.ucs2eng_valid !== 1'b0) $display("FAIL mem_done_valid: got %b want 0", bus.ucs2eng_valid); else n_pass++;
            n_tot++; if (bus.input_mode !== 1'b0) $display("FAIL mem_done_mode: got %b want 0", bus.input_mode); else n_pass++;
         end
      end
      set_idle();
   endtask

   task automatic test_eng_rr();
      logic [NE-1:0] want_g[4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      logic          want_v[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      int            curl[NE]  = '{11, 12, 13, 14};
      for (int c = 0; c < 4; c++) begin
         bus.eng2ucs_valid  = 4'b1010;
         bus.eng2ucs_min[1] = to_lit(2);
         bus.eng2ucs_min[3] = to_lit(4);
         settle();
         n_tot++; if (bus.ucs2eng_grant !== want_g[c]) $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.ucs2eng_grant, want_g[c]); else n_pass++;
         advance();
         n_tot++; if (bus.ucs2eng_valid !== want_v[c] || (want_v[c] && from_lit(bus.ucs2eng) !== ((c == 0) ? 2 : 4)))
            $display("FAIL rr_bcast[%0d]: got v=%b lit=%0d want v=%b", c, bus.ucs2eng_valid, from_lit(bus.ucs2eng), want_v[c]);
         else n_pass++;
      end
      for (int c = 0; c < 5; c++) begin
         bus.eng2ucs_valid = 4'b1111;
         for (int e = 0; e < NE; e++) bus.eng2ucs_min[e] = to_lit(curl[e]);
         settle();
         n_tot++; if (bus.ucs2eng_grant !== (NE'(1) << (c % NE))) $display("FAIL rr4_grant[%0d]: got %b want %b", c, bus.ucs2eng_grant, NE'(1) << (c % NE)); else n_pass++;
         advance();
         n_tot++; if (bus.ucs2eng_valid !== 1'b1 || from_lit(bus.ucs2eng) !== curl[c % NE])
            $display("FAIL rr4_bcast[%0d]: got v=%b lit=%0d want v=1 lit=%0d", c, bus.ucs2eng_valid, from_lit(bus.ucs2eng), curl[c % NE]);
         else n_pass++;
         curl[c % NE] += 4;
      end
      set_idle();
   endtask

   task automatic test_duplicate();
      do_reset();
      mem_cycle(10, 1'b0);
      mem_cycle(0, 1'b1);
      bus.eng2ucs_valid  = 4'b0001;
      bus.eng2ucs_min[0] = to_lit(10);
      settle();
      n_tot++; if (bus.ucs2eng_grant !== 4'b0001) $display("FAIL dup_grant: got %b want 0001", bus.ucs2eng_grant); else n_pass++;
      advance();
      set_idle();
      n_tot++; if (bus.ucs2eng_valid !== 1'b0) $display("FAIL dup_valid: got %b want 0", bus.ucs2eng_valid); else n_pass++;
      n_tot++; if (bus.conflict !== 1'b0) $display("FAIL dup_conflict: got %b want 0", bus.conflict); else n_pass++;
   endtask

   task automatic test_conflict();
      do_reset();
      mem_cycle(10, 1'b0);
      mem_cycle(0, 1'b1);
      bus.eng2ucs_valid  = 4'b0100;
      bus.eng2ucs_min[2] = to_lit(-10);
      settle();
      n_tot++; if (bus.ucs2eng_grant !== 4'b0100) $display("FAIL cf_grant: got %b want 0100", bus.ucs2eng_grant); else n_pass++;
      advance();
      for (int c = 0; c < 20; c++) begin
         bus.eng2ucs_valid = 4'b1111;
         for (int e = 0; e < NE; e++) bus.eng2ucs_min[e] = to_lit(30 + e + 4 * c);
         settle();
         n_tot++; if (bus.conflict !== 1'b1 || bus.ucs2eng_valid !== 1'b0 || bus.ucs2eng_grant !== '0 || bus.mem2ucs_ready !== 1'b0)
            $display("FAIL cf_hold[%0d]: got conf=%b v=%b g=%b rdy=%b want 1 0 0000 0", c, bus.conflict, bus.ucs2eng_valid, bus.ucs2eng_grant, bus.mem2ucs_ready);
         else n_pass++;
         advance();
      end
      set_idle();
   endtask

   task automatic test_stall();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         bus.mem2ucs_valid = 1'b1;
         bus.mem2ucs       = to_lit(10);
         bus.eng2ucs_full  = (c < 5) ? 4'b0100 : 4'b0000;
         settle();
         n_tot++; if (bus.mem2ucs_ready !== exp_rdy) $display("FAIL stall_mem_ready[%0d]: got %b want %b", c, bus.mem2ucs_ready, exp_rdy); else n_pass++;
         advance();
         n_tot++; if (bus.ucs2eng_valid !== exp_uv) $display("FAIL stall_mem_valid[%0d]: got %b want %b", c, bus.ucs2eng_valid, exp_uv); else n_pass++;
      end
      set_idle();
      mem_cycle(0, 1'b1);
      n_tot++; if (bus.ucs2eng_valid !== 1'b0) $display("FAIL stall_mem_nodup: got %b want 0", bus.ucs2eng_valid); else n_pass++;
      for (int c = 0; c < 7; c++) begin
         bus.eng2ucs_valid  = exp_mode() ? 4'b0000 : 4'b0011;
         bus.eng2ucs_min[0] = to_lit(20);
         bus.eng2ucs_min[1] = to_lit(21);
         bus.eng2ucs_full   = (c < 5) ? 4'b0100 : 4'b0000;
         settle();
         n_tot++; if (bus.ucs2eng_grant !== exp_gnt) $display("FAIL stall_eng_grant[%0d]: got %b want %b", c, bus.ucs2eng_grant, exp_gnt); else n_pass++;
         advance();
         n_tot++; if (bus.ucs2eng_valid !== exp_uv || (exp_uv && from_lit(bus.ucs2eng) !== exp_ucs))
            $display("FAIL stall_eng_bcast[%0d]: got v=%b lit=%0d want v=%b lit=%0d", c, bus.ucs2eng_valid, from_lit(bus.ucs2eng), exp_uv, exp_ucs);
         else n_pass++;
      end
      set_idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_cycle(10, 1'b0);
      mem_cycle(0, 1'b1);
      bus.eng2ucs_valid  = 4'b0001;
      bus.eng2ucs_min[0] = to_lit(20);
      settle();
      advance();
      n_tot++; if (bus.ucs2eng_valid !== 1'b1) $display("FAIL mid_inflight: got %b want 1", bus.ucs2eng_valid); else n_pass++;
      rst = 1'b1;
      set_idle();
      model_reset();
      #1;
      n_tot++; if (bus.ucs2eng !== '0 || bus.ucs2eng_valid !== 1'b0 || bus.ucs2eng_grant !== '0 || bus.mem2ucs_ready !== 1'b0)
         $display("FAIL mid_rst_outs: got lit=%0d v=%b g=%b rdy=%b want 0 0 0000 0", from_lit(bus.ucs2eng), bus.ucs2eng_valid, bus.ucs2eng_grant, bus.mem2ucs_ready);
      else n_pass++;
      n_tot++; if (bus.input_mode !== 1'b1 || bus.conflict !== 1'b0) $display("FAIL mid_rst_mode: got mode=%b conf=%b want 1 0", bus.input_mode, bus.conflict); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      mem_cycle(-10, 1'b0);
      n_tot++; if (bus.ucs2eng_valid !== 1'b1 || from_lit(bus.ucs2eng) !== -10)
         $display("FAIL mid_neg10: got v=%b lit=%0d want v=1 lit=-10", bus.ucs2eng_valid, from_lit(bus.ucs2eng));
      else n_pass++;
      @(negedge clk);
      n_tot++; if (bus.conflict !== 1'b0) $display("FAIL mid_noconf: got %b want 0", bus.conflict); else n_pass++;
   endtask

   function automatic int rand_lit();
      int r;
      r = $urandom_range(0, 31);
      if (r == 0) return -64;
      if (r == 1) return 63;
      return int'($urandom_range(0, 24)) - 12;
   endfunction

   task automatic test_random();
      for (int ep = 0; ep < 8; ep++) begin
         do_reset();
         for (int c = 0; c < 50; c++) begin
            bus.mem2ucs_valid = ($urandom_range(0, 3) != 0);
            bus.mem2ucs       = to_lit(rand_lit());
            bus.mem2ucs_done  = (c >= 12) && ($urandom_range(0, 3) == 0);
            bus.eng2ucs_valid = NE'($urandom_range(0, 15));
            for (int e = 0; e < NE; e++) bus.eng2ucs_min[e] = to_lit(rand_lit());
            bus.eng2ucs_full  = ($urandom_range(0, 7) == 0) ? NE'($urandom_range(1, 15)) : '0;
            settle();
            n_tot++; if (bus.mem2ucs_ready !== exp_rdy) $display("FAIL rnd_ready[%0d.%0d]: got %b want %b", ep, c, bus.mem2ucs_ready, exp_rdy); else n_pass++;
            n_tot++; if (bus.ucs2eng_grant !== exp_gnt) $display("FAIL rnd_grant[%0d.%0d]: got %b want %b", ep, c, bus.ucs2eng_grant, exp_gnt); else n_pass++;
            advance();
            n_tot++; if (bus.ucs2eng_valid !== exp_uv || from_lit(bus.ucs2eng) !== exp_ucs)
               $display("FAIL rnd_bcast[%0d.%0d]: got v=%b lit=%0d want v=%b lit=%0d", ep, c, bus.ucs2eng_valid, from_lit(bus.ucs2eng), exp_uv, exp_ucs);
            else n_pass++;
            n_tot++; if (bus.conflict !== m_conf || bus.input_mode !== exp_mode())
               $display("FAIL rnd_state[%0d.%0d]: got conf=%b mode=%b want conf=%b mode=%b", ep, c, bus.conflict, bus.input_mode, m_conf, exp_mode());
            else n_pass++;
         end
         set_idle();
      end
   endtask

   initial begin
      test_reset();
      test_mem_stream();
      test_eng_rr();
      test_duplicate();
      test_conflict();
      test_stall();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
